// File: rtl/arith_unit.sv
// Single-cycle signed arithmetic unit: ADD/SUB on a 32-bit carry-lookahead adder,
// full-width MUL, and DIV returning quotient/remainder. Only the outputs hold state.
module arith_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic        ADD,
    input  logic        SUB,
    input  logic        MUL,
    input  logic        DIV,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] C,
    output logic        cout,
    output logic        diverror
);

    localparam int unsigned OP_W   = 32;
    localparam int unsigned RES_W  = 64;
    localparam int unsigned GRP_W  = 4;
    localparam int unsigned N_GRPS = OP_W / GRP_W;

    logic sel_add, sel_sub, sel_mul, sel_div;

    logic [RES_W-1:0] c_q, c_d;
    logic             cout_q, cout_d;
    logic             diverror_q, diverror_d;

    // Fixed priority ADD > SUB > MUL > DIV
    always_comb begin
        sel_add = ADD;
        sel_sub = !ADD && SUB;
        sel_mul = !ADD && !SUB && MUL;
        sel_div = !ADD && !SUB && !MUL && DIV;
    end

    // Carry-lookahead adder; subtraction is A + ~B + 1
    logic [OP_W-1:0] add_b, gen, prop, sum;
    logic [OP_W:0]   carry;
    logic [3:0]      g4, p4;
    logic            ci, grp_g, grp_p;

    always_comb begin
        add_b    = sel_add ? B : ~B;
        gen      = A & add_b;
        prop     = A ^ add_b;
        carry    = '0;
        carry[0] = !sel_add;
        g4       = '0;
        p4       = '0;
        ci       = 1'b0;
        grp_g    = 1'b0;
        grp_p    = 1'b0;
        for (int k = 0; k < int'(N_GRPS); k++) begin
            g4 = gen[k*GRP_W +: GRP_W];
            p4 = prop[k*GRP_W +: GRP_W];
            ci = carry[k*GRP_W];
            carry[k*GRP_W+1] = g4[0] | (p4[0] & ci);
            carry[k*GRP_W+2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & ci);
            carry[k*GRP_W+3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                             | (p4[2] & p4[1] & p4[0] & ci);
            grp_g = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                  | (p4[3] & p4[2] & p4[1] & g4[0]);
            grp_p = &p4;
            carry[k*GRP_W+4] = grp_g | (grp_p & ci);
        end
        sum = prop ^ carry[OP_W-1:0];
    end

    // Signed multiply on sign-extended operands
    logic signed [RES_W-1:0] a_ext, b_ext, prod;

    always_comb begin
        a_ext = signed'({{OP_W{A[OP_W-1]}}, A});
        b_ext = signed'({{OP_W{B[OP_W-1]}}, B});
        prod  = a_ext * b_ext;
    end

    // Sign-magnitude divide; MIN/-1 naturally wraps to MIN with zero remainder
    logic [OP_W-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
    logic            q_neg;

    always_comb begin
        a_mag  = A[OP_W-1] ? OP_W'(~A + OP_W'(1)) : A;
        b_mag  = B[OP_W-1] ? OP_W'(~B + OP_W'(1)) : B;
        b_safe = (b_mag == '0) ? OP_W'(1) : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        q_neg  = A[OP_W-1] ^ B[OP_W-1];
        quot   = q_neg ? OP_W'(~q_mag + OP_W'(1)) : q_mag;
        rem    = A[OP_W-1] ? OP_W'(~r_mag + OP_W'(1)) : r_mag;
    end

    // Result select; no select holds the registers
    always_comb begin
        c_d        = c_q;
        cout_d     = cout_q;
        diverror_d = diverror_q;
        if (sel_add || sel_sub) begin
            c_d        = {{OP_W{sum[OP_W-1]}}, sum};
            cout_d     = carry[OP_W];
            diverror_d = 1'b0;
        end else if (sel_mul) begin
            c_d        = RES_W'(prod);
            cout_d     = 1'b0;
            diverror_d = 1'b0;
        end else if (sel_div) begin
            cout_d = 1'b0;
            if (B == '0) begin
                c_d        = '0;
                diverror_d = 1'b1;
            end else begin
                c_d        = {rem, quot};
                diverror_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            c_q        <= '0;
            cout_q     <= 1'b0;
            diverror_q <= 1'b0;
        end else begin
            c_q        <= c_d;
            cout_q     <= cout_d;
            diverror_q <= diverror_d;
        end
    end

    assign C        = c_q;
    assign cout     = cout_q;
    assign diverror = diverror_q;

endmodule

// File: tb/tb_arith_unit.sv
// Directed bench for arith_unit with hand-computed expected results.
module tb_arith_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic        ADD, SUB, MUL, DIV;
    logic [31:0] A, B;
    logic [63:0] C;
    logic        cout, diverror;

    int errors = 0;
    int checks = 0;

    arith_unit dut (
        .clk(clk), .clr(clr),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
        .A(A), .B(B),
        .C(C), .cout(cout), .diverror(diverror)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] c_exp,
                       input logic co_exp, input logic de_exp);
        checks++;
        assert (C === c_exp) else begin
            errors++;
            $error("FAIL %s C: got %h expected %h", tag, C, c_exp);
        end
        checks++;
        assert (cout === co_exp) else begin
            errors++;
            $error("FAIL %s cout: got %b expected %b", tag, cout, co_exp);
        end
        checks++;
        assert (diverror === de_exp) else begin
            errors++;
            $error("FAIL %s diverror: got %b expected %b", tag, diverror, de_exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge
    task automatic op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        {ADD, SUB, MUL, DIV} = sel;
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b0;
        {ADD, SUB, MUL, DIV} = 4'b0000;
        A = '0;
        B = '0;
        #12;
        chk("reset", 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b1;

        op(4'b1000, 32'h0000_0007, 32'hFFFF_FFFD);
        chk("add_7_m3", 64'h0000_0000_0000_0004, 1'b1, 1'b0);

        // Asynchronous clear between edges
        #2;
        clr = 1'b0;
        #1;
        chk("async_clr", 64'h0, 1'b0, 1'b0);
        clr = 1'b1;

        op(4'b1000, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_wrap", 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);

        op(4'b0100, 32'd5, 32'd8);
        chk("sub_5_8", 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);

        op(4'b1100, 32'd5, 32'd8);
        chk("add_wins_sub", 64'h0000_0000_0000_000D, 1'b0, 1'b0);

        op(4'b0100, 32'd8, 32'd5);
        chk("sub_8_5", 64'h0000_0000_0000_0003, 1'b1, 1'b0);

        op(4'b0010, 32'hFFFF_FFFD, 32'd7);
        chk("mul_m3_7", 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0);

        op(4'b0010, 32'h8000_0000, 32'h8000_0000);
        chk("mul_min_min", 64'h4000_0000_0000_0000, 1'b0, 1'b0);

        op(4'b0011, 32'd6, 32'd3);
        chk("mul_wins_div", 64'h0000_0000_0000_0012, 1'b0, 1'b0);

        op(4'b0001, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2", 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);

        op(4'b0001, 32'd7, 32'hFFFF_FFFE);
        chk("div_7_m2", 64'h0000_0001_FFFF_FFFD, 1'b0, 1'b0);

        op(4'b0001, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_min_m1", 64'h0000_0000_8000_0000, 1'b0, 1'b0);

        op(4'b1000, 32'h0000_0007, 32'hFFFF_FFFD);
        chk("add_before_div0", 64'h0000_0000_0000_0004, 1'b1, 1'b0);

        op(4'b0001, 32'd123, 32'd0);
        chk("div_by_zero", 64'h0, 1'b0, 1'b1);

        op(4'b0000, 32'd55, 32'd66);
        chk("hold_after_div0", 64'h0, 1'b0, 1'b1);

        op(4'b1000, 32'd1, 32'd1);
        chk("add_1_1", 64'h0000_0000_0000_0002, 1'b0, 1'b0);

        op(4'b0100, 32'd9, 32'd4);
        chk("sub_9_4", 64'h0000_0000_0000_0005, 1'b1, 1'b0);

        op(4'b0000, 32'd1, 32'd2);
        chk("hold_after_sub", 64'h0000_0000_0000_0005, 1'b1, 1'b0);

        // Clear held across a rising edge: the edge must be ignored
        @(negedge clk);
        {ADD, SUB, MUL, DIV} = 4'b1000;
        A = 32'd100;
        B = 32'd200;
        clr = 1'b0;
        @(posedge clk);
        #1;
        chk("edge_during_clr", 64'h0, 1'b0, 1'b0);

        // First edge after release samples fresh inputs
        @(negedge clk);
        clr = 1'b1;
        {ADD, SUB, MUL, DIV} = 4'b0100;
        A = 32'd3;
        B = 32'd10;
        @(posedge clk);
        #1;
        chk("after_release", 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arith_unit.md
ARITH_UNIT -- requirements
Module: arith_unit

Interface
REQ-001 Parameters: none; all widths fixed (32-bit operands, 64-bit result).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-low; clr=0 forces reset state immediately.
REQ-004 ADD  input  1  op select: signed add A+B.
REQ-005 SUB  input  1  op select: signed subtract A-B.
REQ-006 MUL  input  1  op select: signed multiply A*B.
REQ-007 DIV  input  1  op select: signed divide A/B.
REQ-008 A  input  32  operand A, two's complement.
REQ-009 B  input  32  operand B, two's complement.
REQ-010 C  output  64  registered result.
REQ-011 cout  output  1  registered carry-out of the 32-bit adder for ADD/SUB.
REQ-012 diverror  output  1  registered divide-by-zero flag.

Function
REQ-013 Op priority when several selects are high: ADD > SUB > MUL > DIV; only the highest-priority op takes effect.
REQ-014 No select high at a rising edge: C, cout, diverror hold their values.
REQ-015 Latency: exactly one clock; operands and selects sampled at edge N; result visible after edge N; back-to-back ops every cycle allowed, no handshake.
REQ-016 Datapath is combinational between edges: 32-bit carry-lookahead adder (4-bit CLA groups with group generate/propagate), multiplier, divider; only the output registers hold state.
REQ-017 ADD: sum = A+B mod 2^32, carry-in 0; C = sum sign-extended to 64 bits (C[63:32] = all copies of sum[31]); cout = carry out of bit 31.
REQ-018 SUB: computed on the same adder style as A + ~B + 1; C = 32-bit difference sign-extended to 64; cout = carry out of bit 31 (1 when A >= B unsigned).
REQ-019 ADD/SUB overflow: no flag; result wraps mod 2^32 and is then sign-extended from bit 31.
REQ-020 MUL: full signed 64-bit product, C = A*B; never overflows; cout=0.
REQ-021 DIV (B!=0): C[31:0] = quotient truncated toward zero, C[63:32] = remainder with sign of A, |remainder| < |B|, A = q*B + r; cout=0; diverror=0.
REQ-022 DIV special case A=0x80000000, B=0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-023 DIV with B=0: C = 0, diverror = 1, cout = 0.
REQ-024 Any non-DIV op clears diverror to 0; MUL clears cout to 0.

Reset
REQ-025 clr=0: C=0x0000000000000000, cout=0, diverror=0, asynchronously, regardless of clk or selects.
REQ-026 Reset asserted mid-stream: pending sampled result is discarded; first edge after clr returns high samples fresh inputs.
REQ-027 While clr=0, rising edges have no effect.

Verification
REQ-028 clr pulsed low between edges after a prior ADD result -> C=0, cout=0, diverror=0 immediately, before next edge.
REQ-029 ADD A=0x7FFFFFFF B=0x00000001 -> C=0xFFFFFFFF80000000, cout=0; ADD A=7 B=0xFFFFFFFD -> C=0x0000000000000004, cout=1.
REQ-030 SUB A=5 B=8 -> C=0xFFFFFFFFFFFFFFFD, cout=0; SUB with ADD also high (A=5,B=8) -> C=0x000000000000000D (ADD wins).
REQ-031 MUL A=0xFFFFFFFD B=7 -> C=0xFFFFFFFFFFFFFFEB; MUL A=B=0x80000000 -> C=0x4000000000000000.
REQ-032 DIV A=0xFFFFFFF9 (-7) B=2 -> C=0xFFFFFFFFFFFFFFFD (rem -1, quot -3), diverror=0; DIV A=0x80000000 B=0xFFFFFFFF -> C=0x0000000080000000.
REQ-033 DIV A=123 B=0 -> C=0, diverror=1; next cycle no select high -> values held; following ADD A=1 B=1 -> C=2, diverror=0.
